// File: rtl/i2c_slave_rx.sv
// Responder-side I2C receiver: START/STOP detection, address match with ACK, write-byte reception.
// Optional macro I2C_GENERAL_CALL_EN: also accept the general-call address byte 8'h00.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iSCL,
  input  logic       iSDA,
  output logic       oSDA_low,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       addr_match,
  output logic       rw,
  output logic       rd_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       general_call
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, READ_WAIT, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;
  logic                   ack_phase;

  // Synchronizers reset to the idle-bus level so leaving reset creates no edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], iSCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], iSDA};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond, gc_hit;
  logic [7:0] rx_byte;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte    = {shift, sda_s};

`ifdef I2C_GENERAL_CALL_EN
  assign gc_hit = (rx_byte == 8'h00);
`else
  assign gc_hit = 1'b0;
`endif

  // Bus events override bit sampling; ACK slots are driven from falling SCL edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 7'd0;
      ack_phase    <= 1'b0;
      oSDA_low     <= 1'b0;
      busy         <= 1'b0;
      start_det    <= 1'b0;
      stop_det     <= 1'b0;
      addr_match   <= 1'b0;
      rw           <= 1'b0;
      rd_req       <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      general_call <= 1'b0;
    end else begin
      start_det    <= 1'b0;
      stop_det     <= 1'b0;
      addr_match   <= 1'b0;
      rx_valid     <= 1'b0;
      general_call <= 1'b0;
      if (start_cond) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        shift     <= 7'd0;
        ack_phase <= 1'b0;
        oSDA_low  <= 1'b0;
        rd_req    <= 1'b0;
        busy      <= 1'b1;
        start_det <= 1'b1;
      end else if (stop_cond) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        shift     <= 7'd0;
        ack_phase <= 1'b0;
        oSDA_low  <= 1'b0;
        rd_req    <= 1'b0;
        busy      <= 1'b0;
        stop_det  <= 1'b1;
      end else begin
        unique case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_phase <= 1'b0;
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  addr_match <= 1'b1;
                  rw         <= rx_byte[0];
                  state      <= ADDR_ACK;
                end else if (gc_hit) begin
                  addr_match   <= 1'b1;
                  general_call <= 1'b1;
                  rw           <= 1'b0;
                  state        <= ADDR_ACK;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          DATA: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= rx_byte;
                rx_valid  <= 1'b1;
                ack_phase <= 1'b0;
                state     <= DATA_ACK;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                oSDA_low  <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                oSDA_low  <= 1'b0;
                ack_phase <= 1'b0;
                if (state == ADDR_ACK && rw) begin
                  state  <= READ_WAIT;
                  rd_req <= 1'b1;
                end else begin
                  state <= DATA;
                end
              end
            end
          end
          IDLE, READ_WAIT, IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: bit-banged I2C controller plus a queue scoreboard on rx_data.
module tb_i2c_slave_rx;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       oSDA_low, busy, start_det, stop_det, addr_match, rw, rd_req;
  logic [7:0] rx_data;
  logic       rx_valid, general_call;

  int tests_run = 0;
  int tests_failed = 0;
  int n_start, n_stop, n_match, n_valid, n_gc;
  bit osda_seen;
  logic [7:0] exp_q[$];

  assign sda_bus = sda_m & ~oSDA_low;

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .iSCL(scl), .iSDA(sda_bus),
    .oSDA_low(oSDA_low), .busy(busy), .start_det(start_det), .stop_det(stop_det),
    .addr_match(addr_match), .rw(rw), .rd_req(rd_req), .rx_data(rx_data),
    .rx_valid(rx_valid), .general_call(general_call)
  );

  // Pulse counters and the rx_data scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      n_start += int'(start_det);
      n_stop  += int'(stop_det);
      n_match += int'(addr_match);
      n_valid += int'(rx_valid);
      n_gc    += int'(general_call);
      if (oSDA_low) osda_seen = 1'b1;
      if (rx_valid) begin
        logic [7:0] e;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL rx_unexpected got=%h expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            tests_failed++;
            $display("[TB] FAIL rx_data got=%h expected=%h", rx_data, e);
          end
        end
      end
    end
  end

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_start = 0; n_stop = 0; n_match = 0; n_valid = 0; n_gc = 0; osda_seen = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q(2);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;  wait_q();
    scl = 1'b1; wait_q(2);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    ack = oSDA_low & ~sda_bus;
    wait_q();
    scl = 1'b0;
  endtask

  task automatic test_reset();
    logic ack;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({oSDA_low, busy, start_det, stop_det, addr_match, rw, rd_req, rx_valid, general_call} !== 9'd0
        || rx_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got busy=%b sda=%b rx=%h expected all 0", busy, oSDA_low, rx_data);
    end
    reset = 1'b0;
    wait_q();
    i2c_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL busy_mid_addr got=%b expected=1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({oSDA_low, busy, rd_req, rw, rx_valid} !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_addr got busy=%b sda=%b expected 0", busy, oSDA_low);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    i2c_stop();
    ack = 1'b0;
  endtask

  task automatic test_write();
    logic a1, a2;
    clear_counts();
    i2c_start();
    exp_q.push_back(8'hA5);
    send_byte(8'hA0, a1);
    tests_run++;
    if (a1 !== 1'b1 || rw !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_addr_ack got ack=%b rw=%b expected ack=1 rw=0", a1, rw);
    end
    send_byte(8'hA5, a2);
    tests_run++;
    if (a2 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL write_data_ack got=%b expected=1", a2);
    end
    i2c_stop();
    tests_run++;
    if (n_match != 1 || n_valid != 1 || n_stop != 1 || n_start != 1 || busy !== 1'b0 || rx_data !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL write_pulses got match=%0d valid=%0d stop=%0d start=%0d busy=%b rx=%h expected 1/1/1/1/0/a5",
               n_match, n_valid, n_stop, n_start, busy, rx_data);
    end
  endtask

  task automatic test_mismatch();
    logic a;
    clear_counts();
    i2c_start();
    send_byte(8'hA2, a);
    send_bit(1'b0);
    tests_run++;
    if (a !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mismatch_state got ack=%b busy=%b expected ack=0 busy=1", a, busy);
    end
    i2c_stop();
    tests_run++;
    if (n_match != 0 || osda_seen || busy !== 1'b0 || n_valid != 0) begin
      tests_failed++;
      $display("[TB] FAIL mismatch_end got match=%0d sda_seen=%b busy=%b valid=%0d expected 0/0/0/0",
               n_match, osda_seen, busy, n_valid);
    end
  endtask

  task automatic test_read();
    logic a;
    clear_counts();
    i2c_start();
    send_byte(8'hA1, a);
    wait_q(2);
    tests_run++;
    if (a !== 1'b1 || rw !== 1'b1 || rd_req !== 1'b1 || oSDA_low !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_req got ack=%b rw=%b rd_req=%b sda=%b expected 1/1/1/0", a, rw, rd_req, oSDA_low);
    end
    i2c_stop();
    tests_run++;
    if (rd_req !== 1'b0 || n_valid != 0 || n_match != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_end got rd_req=%b valid=%0d match=%0d busy=%b expected 0/0/1/0",
               rd_req, n_valid, n_match, busy);
    end
  endtask

  task automatic test_rep_start();
    logic a1, a2;
    clear_counts();
    i2c_start();
    send_byte(8'hA0, a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    tests_run++;
    if (oSDA_low !== 1'b0 || n_start != 2 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rstart_restart got sda=%b start=%0d busy=%b expected 0/2/1", oSDA_low, n_start, busy);
    end
    send_byte(8'hA1, a2);
    wait_q();
    tests_run++;
    if (a1 !== 1'b1 || a2 !== 1'b1 || rd_req !== 1'b1 || n_valid != 0 || n_match != 2) begin
      tests_failed++;
      $display("[TB] FAIL rstart_read got ack=%b%b rd_req=%b valid=%0d match=%0d expected 11/1/0/2",
               a1, a2, rd_req, n_valid, n_match);
    end
    i2c_stop();
  endtask

  task automatic test_general_call();
    logic a1, a2;
    logic exp_ack;
`ifdef I2C_GENERAL_CALL_EN
    exp_ack = 1'b1;
`else
    exp_ack = 1'b0;
`endif
    clear_counts();
    i2c_start();
    if (exp_ack) exp_q.push_back(8'h3C);
    send_byte(8'h00, a1);
    send_byte(8'h3C, a2);
    i2c_stop();
    tests_run++;
    if (a1 !== exp_ack || a2 !== exp_ack || n_gc != int'(exp_ack) || n_match != int'(exp_ack)
        || n_valid != int'(exp_ack) || osda_seen !== exp_ack) begin
      tests_failed++;
      $display("[TB] FAIL general_call got ack=%b%b gc=%0d match=%0d valid=%0d expected ack=%b each",
               a1, a2, n_gc, n_match, n_valid, exp_ack);
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    logic [7:0] d;
    int nacks;
    clear_counts();
    nacks = 0;
    i2c_start();
    send_byte(8'hA0, a);
    if (a !== 1'b1) nacks++;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i == 0) d = 8'hFF;
      if (i == 1) d = 8'h00;
      exp_q.push_back(d);
      send_byte(d, a);
      if (a !== 1'b1) nacks++;
    end
    i2c_stop();
    tests_run++;
    if (nacks != 0 || n_valid != 4 || exp_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back got nacks=%0d valid=%0d pending=%0d busy=%b expected 0/4/0/0",
               nacks, n_valid, exp_q.size(), busy);
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_rep_start();
    test_general_call();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
